// File: rtl/beta_mem_responder.sv
// Data-memory responder for the Beta processor: serves one LD/ST at a time
// from a word array, ACKs after LATENCY cycles, flags bad addresses, counts transactions.
//
// state  | meaning
// IDLE   | waiting for mem_req; accepts a request on the next edge
// WAIT   | latency countdown after acceptance
// RESP   | one-cycle ACK with error flag and load data
module beta_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_req,
  input  logic             mem_we,
  input  logic [31:0]      mem_addr,
  input  logic [31:0]      mem_wdata,
  output logic [31:0]      mem_rdata,
  output logic             mem_ack,
  output logic             mem_err,
  output logic             busy,
  output logic [CNT_W-1:0] rd_cnt,
  output logic [CNT_W-1:0] wr_cnt
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("beta_mem_responder: LATENCY must lie in 1..15");
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state;
  logic [3:0]  lat_cnt;
  logic        we_q;
  logic        err_q;
  logic [31:0] data_q;
  logic [31:0] mem [DEPTH_WORDS];

  logic [29:0]   word_idx;
  logic [AW-1:0] widx;
  logic          misaligned;
  logic          out_of_range;
  logic          err;
  logic          accept;
  logic [31:0]   rd_word;

  assign word_idx     = mem_addr[31:2];
  assign widx         = word_idx[AW-1:0];
  assign misaligned   = (mem_addr[1:0] != 2'b00);
  assign out_of_range = (word_idx >= 30'(DEPTH_WORDS));
  assign err          = misaligned | out_of_range;
  assign accept       = (state == S_IDLE) && mem_req;
  // Loads sample the array at the accept edge; stores and bad accesses return 0.
  assign rd_word      = (mem_we || err) ? 32'h0 : mem[widx];

  // The array has no reset: a store committed before a reset stays committed.
  always_ff @(posedge clk) begin
    if (accept && mem_we && !err) begin
      mem[widx] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      lat_cnt   <= 4'd0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      data_q    <= 32'h0;
      mem_ack   <= 1'b0;
      mem_err   <= 1'b0;
      mem_rdata <= 32'h0;
      busy      <= 1'b0;
      rd_cnt    <= '0;
      wr_cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (mem_req) begin
            we_q    <= mem_we;
            err_q   <= err;
            data_q  <= rd_word;
            lat_cnt <= 4'(LATENCY - 1);
            busy    <= 1'b1;
            if (LATENCY == 1) begin
              state     <= S_RESP;
              mem_ack   <= 1'b1;
              mem_err   <= err;
              mem_rdata <= rd_word;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (lat_cnt == 4'd0) begin
            state     <= S_RESP;
            mem_ack   <= 1'b1;
            mem_err   <= err_q;
            mem_rdata <= data_q;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        S_RESP: begin
          state     <= S_IDLE;
          mem_ack   <= 1'b0;
          mem_err   <= 1'b0;
          mem_rdata <= 32'h0;
          busy      <= 1'b0;
          if (we_q) begin
            if (wr_cnt != '1) wr_cnt <= wr_cnt + CNT_ONE;
          end else begin
            if (rd_cnt != '1) rd_cnt <= rd_cnt + CNT_ONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // The processor must hold its request until the ACK cycle has ended.
  a_req_held: assert property (@(posedge clk) disable iff (!rst_n)
                               (state != S_IDLE) |-> mem_req)
    else $error("beta_mem_responder: mem_req dropped before mem_ack");

endmodule

// File: tb/tb_beta_mem_responder.sv
// Directed bench for beta_mem_responder: vector table run back-to-back plus
// reset, abort and counter-saturation sequences.
module tb_beta_mem_responder;

  localparam int LAT   = 2;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        req = 1'b0, we = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata;
  logic        ack, err, busy;
  logic [15:0] rd_cnt, wr_cnt;

  logic        s_req = 1'b0, s_we = 1'b0;
  logic [31:0] s_addr = '0, s_wdata = '0;
  logic [31:0] s_rdata;
  logic        s_ack, s_err, s_busy;
  logic [3:0]  s_rd_cnt, s_wr_cnt;

  beta_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .mem_req(req), .mem_we(we), .mem_addr(addr),
    .mem_wdata(wdata), .mem_rdata(rdata), .mem_ack(ack), .mem_err(err),
    .busy(busy), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt));

  beta_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .mem_req(s_req), .mem_we(s_we), .mem_addr(s_addr),
    .mem_wdata(s_wdata), .mem_rdata(s_rdata), .mem_ack(s_ack), .mem_err(s_err),
    .busy(s_busy), .rd_cnt(s_rd_cnt), .wr_cnt(s_wr_cnt));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Drives one request starting just after a rising edge, waits for the ACK
  // (sampled on falling edges), then returns 1 time unit after the edge that
  // leaves the ACK cycle. n counts falling edges from the request, so the
  // cycle before the accept edge is n=1.
  task automatic txn(input bit sel, input bit w, input logic [31:0] a,
                     input logic [31:0] d, input bit drop,
                     output int n, output int ack_at, output logic e,
                     output logic [31:0] rd, output logic b, output bit quiet);
    if (sel) begin s_req = 1'b1; s_we = w; s_addr = a; s_wdata = d; end
    else     begin req = 1'b1; we = w; addr = a; wdata = d; end
    n = 0; ack_at = -1; e = 1'b0; rd = '0; b = 1'b0; quiet = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (sel ? s_ack : ack) begin
        n = i; ack_at = cyc;
        e  = sel ? s_err : err;
        rd = sel ? s_rdata : rdata;
        b  = sel ? s_busy : busy;
        break;
      end else if ((sel ? s_rdata : rdata) != 32'h0) begin
        quiet = 1'b0;
      end
    end
    @(posedge clk); #1;
    if (drop) begin
      if (sel) s_req = 1'b0; else req = 1'b0;
    end
  endtask

  typedef struct {
    bit          w;
    logic [31:0] a;
    logic [31:0] d;
    logic        e;
    logic [31:0] rd;
    int          rdc;
    int          wrc;
  } vec_t;

  vec_t vt[10];

  int          n, at, prev_at;
  logic        e, b;
  logic [31:0] rd;
  bit          q, seen;

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Alternating ST/LD, all issued with the request held high between them.
    vt[0] = '{1'b1, 32'h10,  32'hDEADBEEF, 1'b0, 32'h0,        0, 1};
    vt[1] = '{1'b0, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF, 1, 1};
    vt[2] = '{1'b1, 32'h0,   32'h11111111, 1'b0, 32'h0,        1, 2};
    vt[3] = '{1'b0, 32'h13,  32'h0,        1'b1, 32'h0,        2, 2};
    vt[4] = '{1'b1, 32'h400, 32'hBAD0BAD0, 1'b1, 32'h0,        2, 3};
    vt[5] = '{1'b0, 32'h0,   32'h0,        1'b0, 32'h11111111, 3, 3};
    vt[6] = '{1'b1, 32'h3FC, 32'hCAFEF00D, 1'b0, 32'h0,        3, 4};
    vt[7] = '{1'b0, 32'h3FC, 32'h0,        1'b0, 32'hCAFEF00D, 4, 4};
    vt[8] = '{1'b1, 32'h12,  32'h55555555, 1'b1, 32'h0,        4, 5};
    vt[9] = '{1'b0, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF, 5, 5};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset ack",    ack,    0);
    chk("reset err",    err,    0);
    chk("reset rdata",  rdata,  0);
    chk("reset busy",   busy,   0);
    chk("reset rd_cnt", rd_cnt, 0);
    chk("reset wr_cnt", wr_cnt, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Accept at edge k, ACK in the cycle after edge k+LAT, then one IDLE
    // cycle before the next accept: ACKs are LAT+2 cycles apart.
    prev_at = 0;
    for (int i = 0; i < 10; i++) begin
      txn(1'b0, vt[i].w, vt[i].a, vt[i].d, (i == 9), n, at, e, rd, b, q);
      chk($sformatf("v%0d latency", i), n, LAT + 2);
      chk($sformatf("v%0d err", i), e, vt[i].e);
      chk($sformatf("v%0d rdata", i), rd, vt[i].rd);
      chk($sformatf("v%0d busy_at_ack", i), b, 1);
      chk($sformatf("v%0d rdata_quiet", i), q, 1);
      chk($sformatf("v%0d rd_cnt", i), rd_cnt, vt[i].rdc);
      chk($sformatf("v%0d wr_cnt", i), wr_cnt, vt[i].wrc);
      if (i > 0) chk($sformatf("v%0d ack_spacing", i), at - prev_at, LAT + 2);
      prev_at = at;
    end
    chk("idle busy", busy, 0);

    // Reset asserted during an ACK cycle clears outputs immediately.
    req = 1'b1; we = 1'b0; addr = 32'h10;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ack) begin seen = 1'b1; break; end
    end
    chk("t1 ack seen", seen, 1);
    chk("t1 rdata before reset", rdata, 32'hDEADBEEF);
    #1 rst_n = 1'b0;
    #1;
    chk("t1 ack",    ack,    0);
    chk("t1 err",    err,    0);
    chk("t1 rdata",  rdata,  0);
    chk("t1 busy",   busy,   0);
    chk("t1 rd_cnt", rd_cnt, 0);
    chk("t1 wr_cnt", wr_cnt, 0);
    req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t1 idle after release", busy, 0);
    txn(1'b0, 1'b0, 32'h10, 32'h0, 1'b1, n, at, e, rd, b, q);
    chk("t1 post latency", n, LAT + 2);
    chk("t1 post rdata", rd, 32'hDEADBEEF);
    chk("t1 post rd_cnt", rd_cnt, 1);

    // Abort a store during WAIT: no ACK, no count, but the data is in the array.
    req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'hA5A5A5A5;
    @(posedge clk);
    @(negedge clk);
    chk("t5 busy in wait", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t5 busy in reset", busy, 0);
    req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack) seen = 1'b1;
    end
    chk("t5 no ack", seen, 0);
    chk("t5 wr_cnt", wr_cnt, 0);
    @(posedge clk); #1;
    txn(1'b0, 1'b0, 32'h20, 32'h0, 1'b1, n, at, e, rd, b, q);
    chk("t5 ld err", e, 0);
    chk("t5 ld rdata", rd, 32'hA5A5A5A5);
    chk("t5 rd_cnt", rd_cnt, 1);
    chk("t5 wr_cnt after ld", wr_cnt, 0);

    // LATENCY=1, CNT_W=4 instance: ACK in the cycle right after the accept edge.
    txn(1'b1, 1'b1, 32'h8, 32'h77, 1'b1, n, at, e, rd, b, q);
    chk("t6 st latency", n, 2);
    chk("t6 wr_cnt", s_wr_cnt, 1);
    for (int i = 1; i <= 17; i++) begin
      txn(1'b1, 1'b0, 32'h8, 32'h0, (i == 17), n, at, e, rd, b, q);
      if (i == 1) begin
        chk("t6 ld latency", n, 2);
        chk("t6 ld rdata", rd, 32'h77);
      end
      chk($sformatf("t6 rd_cnt after %0d", i), s_rd_cnt, (i < 15) ? i : 15);
    end
    chk("t6 wr_cnt final", s_wr_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
